topk_sort_stream: RTL

Streaming top-K selector with optional ReLU front-end.
- Accepts (value, index) pairs over a valid/ready handshake and keeps the K best entries in rank order, ascending or descending.
- Streams the ranked list out on request.
- Parametrised in data width, index width and depth. One insertion per cycle.
- Sits after the accumulator/activation stage of the accelerator, feeding classification and result readout.

---
 rtl/sort_pkg.sv | 22 ++
 rtl/topk_sort_stream_if.sv | 31 +++
 rtl/topk_sort_stream_slot.sv | 38 +++
 rtl/topk_sort_stream.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the streaming top-K selector.
//   state_t : FILL (accepting inserts) / DRAIN (streaming the ranked list)
//   beats() : rank comparison, sign-extended to MAX_W so any DATA_W <= MAX_W works
// The slot payload struct depends on the block's width parameters, so it is
// declared next to those parameters in topk_sort_stream.
package sort_pkg;

  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // True when cand must be ranked ahead of held; ties are never a win.
  function automatic logic beats(input logic signed [MAX_W-1:0] cand,
                                 input logic signed [MAX_W-1:0] held,
                                 input logic                    asce);
    return asce ? (cand < held) : (cand > held);
  endfunction

endpackage

// File: rtl/topk_sort_stream_if.sv
// Input and output streams of the top-K selector.
//   in_valid/in_ready/in_data/in_index      : (value, index) pairs in
//   out_valid/out_ready/out_data/out_index/out_last : ranked entries out
// master = producer/consumer side, slave = the selector.
interface topk_sort_stream_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 32
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_index;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [IDX_W-1:0]  out_index;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_index, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, in_index, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );

endinterface

// File: rtl/topk_sort_stream_slot.sv
// topk_slot: one cell of the ranked list. Holds its entry, or on an insert
// either takes the entry from the slot above (insert point is above this
// slot) or loads the new entry (this slot is the insert point).
//   clk, rst         : clock, async active-high reset
//   clear            : synchronous wipe, highest priority
//   insert           : an entry is accepted this cycle
//   ge_self/ge_above : insert point is at-or-above this slot / the slot above
//   above, new_e     : neighbour-above entry, incoming entry
//   q                : registered entry (MSB is the valid bit)
module topk_slot #(
  parameter int unsigned SLOT_W = 65
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              insert,
  input  logic              ge_self,
  input  logic              ge_above,
  input  logic [SLOT_W-1:0] above,
  input  logic [SLOT_W-1:0] new_e,
  output logic [SLOT_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (insert) begin
      if (ge_above) begin
        q <= above;
      end else if (ge_self) begin
        q <= new_e;
      end
    end
  end

endmodule

// File: rtl/topk_sort_stream.sv
// topk_sort_stream: streaming top-K selector. Keeps the K best (value, index)
// pairs in rank order (ascending or descending, stable on ties) and streams
// the list out on flush without destroying it.
//   clk, rst : clock, async active-high reset
//   bus      : topk_sort_stream_if.slave (input and output streams)
//   asce     : 1 = keep K smallest ascending, 0 = K largest descending
//              (latched on the first insert into an empty list)
//   clear    : synchronous wipe, one-cycle pulse, highest priority
//   flush    : start readout, one-cycle pulse
//   count    : occupied slots 0..K
//   done     : one-cycle pulse when readout completes
// Build option: define SORT_RELU_EN to clamp negative inputs to 0 before
// compare and storage.
module topk_sort_stream
  import sort_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = 32,
  parameter int unsigned K      = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  topk_sort_stream_if.slave        bus,
  input  logic                     asce,
  input  logic                     clear,
  input  logic                     flush,
  output logic [$clog2(K+1)-1:0]   count,
  output logic                     done
);

  localparam int unsigned CNT_W = $clog2(K+1);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  index;
  } slot_t;

  localparam int unsigned SLOT_W = $bits(slot_t);

  state_t            state;
  logic              asce_q;
  logic [CNT_W-1:0]  rd_ptr;

  slot_t             slot_q [K];
  slot_t             above  [K];
  slot_t             new_e;
  logic [DATA_W-1:0] new_data;
  logic [K-1:0]      ge;
  logic [K-1:0]      ge_up;

  logic              insert;
  logic              asce_eff;
  logic [CNT_W-1:0]  count_nxt_c;
  logic [CNT_W-1:0]  nptr;
  logic [DATA_W-1:0] head_data;
  logic [IDX_W-1:0]  head_index;
  logic [DATA_W-1:0] sel_data;
  logic [IDX_W-1:0]  sel_index;

  assign bus.in_ready = (state == FILL);
  assign insert       = bus.in_valid && bus.in_ready && !clear;
  // Until the first entry lands, the live asce pin decides the order.
  assign asce_eff     = (count == '0) ? asce : asce_q;

  // Optional ReLU front-end.
  always_comb begin
`ifdef SORT_RELU_EN
    new_data = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
    new_data = bus.in_data;
`endif
  end

  assign new_e = '{valid: 1'b1, data: new_data, index: bus.in_index};

  // Parallel compare; ge[i] means the insert point is at slot i or above.
  always_comb begin
    logic acc;
    acc = 1'b0;
    ge  = '0;
    for (int i = 0; i < int'(K); i++) begin
      acc = acc | !slot_q[i].valid
                | beats(MAX_W'($signed(new_data)), MAX_W'($signed(slot_q[i].data)), asce_eff);
      ge[i] = acc;
    end
  end

  assign ge_up = {ge[K-2:0], 1'b0};

  always_comb begin
    above[0] = '0;
    for (int i = 1; i < int'(K); i++) begin
      above[i] = slot_q[i-1];
    end
  end

  for (genvar g = 0; g < int'(K); g++) begin : g_slot
    topk_slot #(.SLOT_W(SLOT_W)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .insert   (insert),
      .ge_self  (ge[g]),
      .ge_above (ge_up[g]),
      .above    (above[g]),
      .new_e    (new_e),
      .q        (slot_q[g])
    );
  end

  always_comb begin
    count_nxt_c = count;
    if (clear) begin
      count_nxt_c = '0;
    end else if (insert && (count < CNT_W'(K))) begin
      count_nxt_c = count + CNT_W'(1);
    end
  end

  // Slot 0 as it will be after this edge, so an insert coinciding with flush
  // is visible in the first output entry.
  assign head_data  = (insert && ge[0]) ? new_data     : slot_q[0].data;
  assign head_index = (insert && ge[0]) ? bus.in_index : slot_q[0].index;

  // Next entry to present during DRAIN; the list is frozen while draining.
  assign nptr = rd_ptr + CNT_W'(1);

  always_comb begin
    sel_data  = '0;
    sel_index = '0;
    for (int i = 0; i < int'(K); i++) begin
      if (CNT_W'(i) == nptr) begin
        sel_data  = slot_q[i].data;
        sel_index = slot_q[i].index;
      end
    end
  end

  // FSM, count, readout pointer and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= FILL;
      asce_q        <= 1'b0;
      rd_ptr        <= '0;
      count         <= '0;
      done          <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      done  <= 1'b0;
      count <= count_nxt_c;
      if (insert && (count == '0)) begin
        asce_q <= asce;
      end
      if (clear) begin
        state         <= FILL;
        rd_ptr        <= '0;
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            if (flush) begin
              if (count_nxt_c == '0) begin
                done <= 1'b1;
              end else begin
                state         <= DRAIN;
                rd_ptr        <= '0;
                bus.out_valid <= 1'b1;
                bus.out_data  <= head_data;
                bus.out_index <= head_index;
                bus.out_last  <= (count_nxt_c == CNT_W'(1));
              end
            end
          end
          DRAIN: begin
            if (bus.out_valid && bus.out_ready) begin
              if (bus.out_last) begin
                state         <= FILL;
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
                done          <= 1'b1;
              end else begin
                rd_ptr        <= nptr;
                bus.out_data  <= sel_data;
                bus.out_index <= sel_index;
                bus.out_last  <= ((nptr + CNT_W'(1)) == count);
              end
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule
